// File: rtl/bram_pkg.sv
// Shared constants and FSM encoding for the block-RAM read/write initiators.
// Both initiators use the same geometry and state names.
package bram_pkg;

  localparam int BRAM_AW    = 10;
  localparam int BRAM_DW    = 24;
  localparam int BRAM_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } bram_state_e;

endpackage

// File: rtl/bram_rd_fifo.sv
// Small register FIFO that holds words returned by the RAM until the consumer takes them.
// The head is a plain register read, so the stream data is stable while it is not being popped.
module bram_rd_fifo #(
  parameter int  DW    = 24,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic [PW:0]   occ_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   occ_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      // Push and pop in the same cycle cancel out in the occupancy count.
      case ({wr_en_i, rd_en_i})
        2'b10:   occ_q <= occ_q + (PW+1)'(1);
        2'b01:   occ_q <= occ_q - (PW+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign occ_o     = occ_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_en_i && !rd_en_i && occ_q == (PW+1)'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rd_en_i && occ_q == '0));

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side initiator: turns a (base, count) command into sequential RAM reads and
// a valid/ready output stream, hiding the RAM's registered read latency.
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int  AW    = BRAM_AW,
  parameter int  DW    = BRAM_DW,
  parameter int  DEPTH = BRAM_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output bram_state_e   dbg_state,
  output logic [PW:0]   dbg_occ
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  bram_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   issue_left_q, issue_left_d;
  logic [AW:0]   retire_left_q, retire_left_d;
  logic          rd_en_q, rd_en_d;
  logic          rd_pipe_q;
  logic          done_q, done_d;
  logic [PW:0]   occ;
  logic [PW+1:0] used;
  logic          credit_ok;
  logic          handshake;

  // Stream handshake: a word transfers on a rising edge where out_valid and out_ready
  // are both high; out_valid never drops and out_data never changes until that edge.
  assign out_valid = (occ != '0);
  assign handshake = out_valid && out_ready;
  assign out_last  = out_valid && (retire_left_q == ONE);

  // Reads in flight (registered enable plus the RAM's output stage) reserve buffer slots.
  assign used      = {1'b0, occ} + (PW+2)'(rd_en_q) + (PW+2)'(rd_pipe_q);
  assign credit_ok = (used < (PW+2)'(DEPTH));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    issue_left_d  = issue_left_q;
    retire_left_d = retire_left_q;
    rd_en_d       = 1'b0;
    done_d        = 1'b0;
    if (handshake) retire_left_d = retire_left_q - ONE;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d        = base;
          retire_left_d = count;
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            rd_en_d      = 1'b1;
            issue_left_d = count - ONE;
            state_d      = (count == ONE) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          rd_en_d      = 1'b1;
          addr_d       = addr_q + AW'(1);
          issue_left_d = issue_left_q - ONE;
          if (issue_left_q == ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake && retire_left_q == ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      issue_left_q  <= '0;
      retire_left_q <= '0;
      rd_en_q       <= 1'b0;
      rd_pipe_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      issue_left_q  <= issue_left_d;
      retire_left_q <= retire_left_d;
      rd_en_q       <= rd_en_d;
      rd_pipe_q     <= rd_en_q;
      done_q        <= done_d;
    end
  end

  bram_rd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (rd_pipe_q),
    .wr_data_i (mem_rd_data),
    .rd_en_i   (handshake),
    .rd_data_o (out_data),
    .occ_o     (occ)
  );

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = addr_q;
  assign dbg_state   = state_q;
  assign dbg_occ     = occ;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural registered-read RAM,
// a scoreboard queue of expected stream words and a negedge monitor.
module tb_bram_stream_reader;
  import bram_pkg::*;

  localparam int AW = 10;
  localparam int DW = 24;

  logic          clk, rst_n, start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic          busy, done, mem_rd_en, out_valid, out_last, out_ready;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data, out_data;
  bram_state_e   dbg_state;
  logic [2:0]    dbg_occ;

  logic [DW-1:0] ram [1024];
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_seen[$];
  int            total = 0, bad = 0;
  int            hs_cnt = 0, done_cnt = 0, max_occ = 0;
  logic          stall_pend = 1'b0;
  logic [DW+1:0] stall_word;
  logic [DW:0]   e_word;

  bram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .dbg_state(dbg_state), .dbg_occ(dbg_occ)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 24'h0A0000 + 24'(i);
  end

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) chk("stall_stable", 32'({out_valid, out_last, out_data}), 32'(stall_word));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL stray_word: got %h, expected no word", out_data);
        end else begin
          e_word = exp_q.pop_front();
          chk("word_data", 32'(out_data), 32'(e_word[DW-1:0]));
          chk("word_last", 32'(out_last), 32'(e_word[DW]));
        end
        hs_cnt++;
      end
      stall_pend = out_valid && !out_ready;
      stall_word = {out_valid, out_last, out_data};
      if (mem_rd_en) addr_seen.push_back(mem_rd_addr);
      if (int'(dbg_occ) > max_occ) max_occ = int'(dbg_occ);
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic push_seq(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), 24'h0A0000 + 24'((int'(b) + i) % 1024)});
  endtask

  task automatic run_cmd(input logic [AW-1:0] b, input logic [AW:0] n, input bit rnd,
                         input bit mid, output int lat, output int dcyc, output logic busy_at_done);
    lat = -1;
    dcyc = -1;
    busy_at_done = 1'b1;
    start = 1'b1;
    base  = b;
    count = n;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (mid && c == 2) begin
        start = 1'b1;
        base  = b + 10'd300;
        count = 11'd5;
      end
      if (mid && c == 3) start = 1'b0;
      if (lat < 0 && out_valid) lat = c;
      if (done) begin
        dcyc = c;
        busy_at_done = busy;
        break;
      end
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    total++;
    if (dcyc < 0) begin
      bad++;
      $display("FAIL cmd_timeout: got no done for base=%0d count=%0d, expected done", b, n);
    end
  endtask

  task automatic check_addrs(input string nm, input logic [AW-1:0] b, input int n);
    chk({nm, "_addr_cnt"}, 32'(addr_seen.size()), 32'(n));
    for (int i = 0; i < n && i < addr_seen.size(); i++)
      chk({nm, "_addr"}, 32'(addr_seen[i]), 32'(b + AW'(i)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, dcyc, hs0, d0;
    logic bz;
    logic [AW-1:0] wrap_addr [4];

    rst_n = 1'b0; start = 1'b0; base = '0; count = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // base 0, six words, consumer always ready
    addr_seen.delete();
    push_seq(10'd0, 6);
    run_cmd(10'd0, 11'd6, 1'b0, 1'b0, lat, dcyc, bz);
    chk("t1_latency", 32'(lat), 2);
    chk("t1_done_cycle", 32'(dcyc), 8);
    chk("t1_busy_at_done", 32'(bz), 0);
    check_addrs("t1", 10'd0, 6);
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(done), 0);

    // address wrap 1022, 1023, 0, 1
    addr_seen.delete();
    exp_q.push_back({1'b0, 24'h0A03FE});
    exp_q.push_back({1'b0, 24'h0A03FF});
    exp_q.push_back({1'b0, 24'h0A0000});
    exp_q.push_back({1'b1, 24'h0A0001});
    wrap_addr[0] = 10'd1022; wrap_addr[1] = 10'd1023; wrap_addr[2] = 10'd0; wrap_addr[3] = 10'd1;
    run_cmd(10'd1022, 11'd4, 1'b0, 1'b0, lat, dcyc, bz);
    chk("t2_done_cycle", 32'(dcyc), 6);
    chk("t2_addr_cnt", 32'(addr_seen.size()), 4);
    for (int i = 0; i < 4 && i < addr_seen.size(); i++)
      chk("t2_addr", 32'(addr_seen[i]), 32'(wrap_addr[i]));

    // random backpressure
    addr_seen.delete();
    push_seq(10'd100, 16);
    run_cmd(10'd100, 11'd16, 1'b1, 1'b0, lat, dcyc, bz);
    check_addrs("t3", 10'd100, 16);
    chk("t3_queue_empty", 32'(exp_q.size()), 0);

    // zero count
    addr_seen.delete();
    run_cmd(10'd5, 11'd0, 1'b0, 1'b0, lat, dcyc, bz);
    chk("t4_done_cycle", 32'(dcyc), 0);
    chk("t4_busy", 32'(bz), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_reads", 32'(addr_seen.size()), 0);

    // start while busy is ignored
    addr_seen.delete();
    push_seq(10'd200, 5);
    run_cmd(10'd200, 11'd5, 1'b0, 1'b1, lat, dcyc, bz);
    chk("t5_done_cycle", 32'(dcyc), 7);
    repeat (3) @(posedge clk);
    #1;
    check_addrs("t5", 10'd200, 5);
    chk("t5_idle_after", 32'(busy), 0);

    // reset after three of eight words
    push_seq(10'd0, 8);
    hs0 = hs_cnt;
    start = 1'b1; base = 10'd0; count = 11'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (hs_cnt - hs0 >= 3) break;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_hs_before_rst", 32'(hs_cnt - hs0), 3);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_rd_en", 32'(mem_rd_en), 0);
    chk("t6_rst_rd_addr", 32'(mem_rd_addr), 0);
    chk("t6_rst_data", 32'(out_data), 0);
    chk("t6_rst_last", 32'(out_last), 0);
    exp_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_done", 32'(done_cnt), 32'(d0));
    chk("t6_no_words", 32'(hs_cnt - hs0), 3);

    addr_seen.delete();
    push_seq(10'd10, 3);
    run_cmd(10'd10, 11'd3, 1'b0, 1'b0, lat, dcyc, bz);
    chk("t6_fresh_latency", 32'(lat), 2);
    chk("t6_fresh_done_cycle", 32'(dcyc), 5);
    check_addrs("t6_fresh", 10'd10, 3);

    repeat (5) @(posedge clk);
    #1;
    chk("end_queue_empty", 32'(exp_q.size()), 0);
    chk("end_done_count", 32'(done_cnt), 6);
    total++;
    if (max_occ > 4) begin
      bad++;
      $display("FAIL max_occ: got %0d, expected at most 4", max_occ);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
